// File: rtl/alu_cmd_issuer.sv
// Initiator for a combinational ALU: buffers commands in a FIFO, drives one
// command per DRIVE cycle, and returns the captured result over valid/ready.
module alu_cmd_issuer #(
    parameter int              DATA_W     = 32,
    parameter int              OP_W       = 5,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [OP_W-1:0] MAX_OP     = 5'b01100,
    parameter int              OVF_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_src1,
    input  logic [DATA_W-1:0] cmd_src2,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_overflow,
    output logic              res_illegal,
    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow,
    input  logic              ovf_clr,
    output logic [OVF_W-1:0]  ovf_count,
    output logic              busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, RESULT} state_t;

    state_t      state, state_nxt;
    cmd_t        fifo_mem [FIFO_DEPTH];
    cmd_t        cmd_in, head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push, pop, capture, release_res;
    logic        head_legal, cur_illegal;

    assign cmd_in     = '{op: cmd_op, src1: cmd_src1, src2: cmd_src2};
    assign head       = fifo_mem[rd_ptr[AW-1:0]];
    assign head_legal = (head.op <= MAX_OP);

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= cmd_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                capture   = 1'b1;
                state_nxt = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = DRIVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operands hold between commands; only the enable is pulsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_enable  <= 1'b0;
            alu_op      <= '0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            cur_illegal <= 1'b0;
        end else if (pop) begin
            alu_enable  <= head_legal;
            alu_op      <= head.op;
            alu_src1    <= head.src1;
            alu_src2    <= head.src2;
            cur_illegal <= !head_legal;
        end else if (capture) begin
            alu_enable  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_overflow <= 1'b0;
            res_illegal  <= 1'b0;
        end else if (capture) begin
            res_valid    <= 1'b1;
            res_data     <= cur_illegal ? '0 : alu_out;
            res_overflow <= !cur_illegal && alu_overflow;
            res_illegal  <= cur_illegal;
        end else if (release_res) begin
            res_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (capture && !cur_illegal && alu_overflow && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU interface: accepts ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Drives one command at a time onto the combinational ALU (alu_enable/alu_op/src1/src2), captures alu_out/alu_overflow and returns results over a second valid/ready stream.
- Sits between the datapath controller and the ALU. Keeps a saturating overflow-event counter for debug.

Parameters:
DATA_W, 32, operand/result width
OP_W, 5, ALU opcode width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
MAX_OP, 5'b01100, highest legal opcode (ABS); opcodes above are illegal
OVF_W, 16, overflow counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_op  in  OP_W  ALU opcode
cmd_src1  in  DATA_W  operand 1
cmd_src2  in  DATA_W  operand 2
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  DATA_W  captured alu_out
res_overflow  out  1  captured alu_overflow
res_illegal  out  1  opcode was > MAX_OP
alu_enable  out  1  to ALU
alu_op  out  OP_W  to ALU
alu_src1  out  DATA_W  to ALU
alu_src2  out  DATA_W  to ALU
alu_out  in  DATA_W  from ALU (combinational)
alu_overflow  in  1  from ALU
ovf_clr  in  1  synchronous clear of ovf_count
ovf_count  out  OVF_W  saturating count of results with overflow
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst_n low, async): FIFO emptied, state IDLE. All registered outputs are 0: res_valid, res_data, res_overflow, res_illegal, alu_enable, alu_op, alu_src1, alu_src2, ovf_count.
- cmd_ready = !fifo_full, combinational. It is 1 out of reset.
- Push on cmd_valid && cmd_ready. Commands are kept in strict order.
- When full, no push is taken even if a pop happens in the same cycle.
- FSM states: IDLE, DRIVE, RESULT.
- IDLE: if FIFO non-empty, pop the head, load alu_op/alu_src1/alu_src2 registers, go to DRIVE.
  - alu_enable is registered 1 for a legal opcode.
  - alu_enable is 0 if op > MAX_OP.
- DRIVE (exactly 1 cycle):
  - At the clock edge, capture res_data = alu_out and res_overflow = alu_overflow.
  - If illegal: res_data = 0, res_overflow = 0, res_illegal = 1.
  - Set res_valid = 1, drop alu_enable to 0, go to RESULT.
  - alu_op/alu_src* hold their last values outside DRIVE.
- RESULT: res_valid and the result fields hold stable until res_valid && res_ready.
  - On handshake with FIFO non-empty: pop the next command and go straight to DRIVE, with res_valid dropping to 0.
  - On handshake with FIFO empty: go to IDLE.
- Latency: command accepted at edge N with an idle, empty block gives DRIVE in cycle after edge N+1 and res_valid high after edge N+2.
- Throughput: 1 result per 2 cycles when res_ready is held high.
- Capacity: 1 command in flight plus FIFO_DEPTH buffered. With res_ready low, FIFO_DEPTH+1 back-to-back commands are accepted.
- ovf_count: increments at the DRIVE capture edge when a legal op has alu_overflow = 1.
  - Saturates at all-ones.
  - ovf_clr has priority over increment in the same cycle (result 0).
- Reset mid-operation: any in-flight or buffered command is discarded. No result is produced after rst_n deasserts.
- The ALU is purely combinational. The block never sends alu_enable = 1 for more than one consecutive cycle per command.

Test Plan:
1. ADD (5'b00000): src1 = 0x7FFFFFFF, src2 = 0x00000001 → res_valid 2 edges after accept, res_data = 0x80000000, res_overflow = 1, ovf_count = 1, alu_enable high for exactly 1 cycle.
2. res_ready = 0, 6 back-to-back SUB commands → exactly 5 accepted and cmd_ready low. Raising res_ready then yields 5 results in order at 1 per 2 cycles.
3. Illegal op 5'b10000 (src 0x5, 0x3) → res_data = 0, res_illegal = 1, res_overflow = 0, alu_enable never asserted, ovf_count unchanged.
4. MAX (5'b01010) src1 = 0xFFFFFFFF, src2 = 0x1 → 0x00000001. Then MIN (5'b01011) with the same operands → 0xFFFFFFFF. Results return in order.
5. OVF_W = 2: five overflowing ADDs → ovf_count = 3 (saturated). ovf_clr asserted in the same cycle as a 6th overflow capture → ovf_count = 0.
6. rst_n pulsed low during DRIVE with 2 commands queued → alu_enable, res_valid and busy go to 0 immediately, cmd_ready = 1. No result appears in the 10 cycles after release.
